pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Converts single-cycle trigger strobes into clean, fixed-length output pulses of programmable width. It is the level-generating counterpart of the coprocessor's edge-detection front end. It drives pulse-width-sensitive outputs such as LEDs, strobes to slower peripherals and handshake lines from internal 1-cycle events. The block provides optional retriggering, a post-pulse hold-off window and status flags for accepted and dropped triggers.

## Interface
Parameters:
- WIDTH_BITS, 16: width of the `width` input and of the pulse counter.
- RETRIGGER, 0: 1 = a trigger during an active pulse reloads the counter; 0 = that trigger is dropped.
- HOLDOFF, 0: number of forced-low cycles after each pulse during which triggers are dropped; 0 disables.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trig  in  1  trigger strobe, sampled every cycle; normally a 1-cycle pulse.
- width  in  WIDTH_BITS  requested pulse length in cycles; sampled only in a cycle where trig is accepted.
- pulse_out  out  1  stretched output pulse, registered.
- busy  out  1  high while state ≠ IDLE.
- pulse_done  out  1  1-cycle strobe marking the end of a pulse.
- trig_dropped  out  1  1-cycle strobe: a trigger with width ≠ 0 arrived and was ignored.

## Operation
- FSM states: IDLE, ACTIVE, HOLD. The counter cnt is WIDTH_BITS wide and is shared by ACTIVE (pulse length) and HOLD (hold-off). HOLDOFF must fit in WIDTH_BITS.
- IDLE:
  - trig=1 and width≠0: go to ACTIVE, cnt ← width.
  - trig=1 and width=0: no-op. Stay in IDLE, no drop flag.
- ACTIVE, each cycle:
  - RETRIGGER=1, trig=1 and width≠0: cnt ← width and stay in ACTIVE. The reload wins over expiry.
  - Otherwise, if cnt=1: go to HOLD (cnt ← HOLDOFF) when HOLDOFF>0, else go to IDLE. Assert pulse_done next cycle.
  - Otherwise: cnt ← cnt−1.
  - RETRIGGER=0 with trig=1 and width≠0: trig_dropped next cycle. This applies in the last ACTIVE cycle too.
- HOLD:
  - cnt decrements each cycle; at cnt=1, go to IDLE.
  - Any trig with width≠0 sets trig_dropped. Retrigger is never honoured in HOLD.
- Output decoding:
  - pulse_out = (state==ACTIVE).
  - busy = (state≠IDLE).
  - pulse_done and trig_dropped are registered 1-cycle strobes.
- Reset (reset_n=0, at any time, including mid-pulse or mid-hold):
  - state ← IDLE, cnt ← 0.
  - pulse_out, busy, pulse_done and trig_dropped go to 0 immediately.
  - First possible acceptance is the first rising edge after reset_n rises.

## Timing
- Trigger accepted in cycle k: pulse_out is high in cycles k+1 … k+width, exactly `width` cycles.
- pulse_done is high in cycle k+width+1, coincident with the first low cycle of pulse_out.
- HOLDOFF=0: a trigger in cycle k+width+1 is accepted. Minimum low gap between pulses is 1 cycle.
- HOLDOFF=H: busy stays high through k+width+H. The first acceptable trigger is in cycle k+width+H+1.
- Retrigger at cycle t (RETRIGGER=1): pulse_out stays high continuously through t+width(t). No pulse_done is generated for the superseded pulse.
- trig_dropped is high the cycle after the offending trigger. Consecutive dropped triggers produce consecutive strobes.
- The width input is ignored in every cycle without an accepted trigger or reload. Changing it mid-pulse has no effect.
- Maximum pulse length is 2^WIDTH_BITS−1 cycles. There is no wrap-around: cnt never decrements below 1 in ACTIVE or HOLD.

## Test plan
- Basic pulse: reset, then trig at cycle 10 with width=5 → pulse_out high in cycles 11–15, pulse_done at 16, busy high 11–15, trig_dropped never high.
- Zero width and mid-pulse width change: trig with width=0 → no pulse, no flags. Then trig with width=3 while width changes to 9 during the pulse → exactly 3 high cycles.
- No retrigger (RETRIGGER=0): width=4, trig at 10 and 12 → pulse_out high 11–14, trig_dropped at 13, one pulse_done at 15. A trig at 15 is accepted → pulse_out high 16–19.
- Retrigger (RETRIGGER=1): width=4, trig at 10 and 13 → pulse_out high 11–17 without a gap, single pulse_done at 18. A trig in the expiry cycle also extends the pulse.
- Hold-off (HOLDOFF=3): width=2, trig at 10 → pulse_out high 11–12, busy high 11–15. A trig at 14 → trig_dropped at 15. A trig at 16 is accepted → pulse_out high 17–18.
- Async reset mid-pulse: width=100, trig at 10, reset_n low at 30.4 ns-offset between edges → all outputs 0 immediately. After release, trig with width=2 → normal 2-cycle pulse.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle trigger strobes into fixed-length output pulses with optional
// retriggering, a post-pulse hold-off window and accepted/dropped status strobes.
module pulse_stretcher #(
    parameter int WIDTH_BITS = 16,
    parameter int RETRIGGER  = 0,
    parameter int HOLDOFF    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trig,
    input  logic [WIDTH_BITS-1:0] width,
    output logic                  pulse_out,
    output logic                  busy,
    output logic                  pulse_done,
    output logic                  trig_dropped
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam logic [WIDTH_BITS-1:0] CNT_ONE   = WIDTH_BITS'(1);
    localparam logic [WIDTH_BITS-1:0] HOLD_LOAD = WIDTH_BITS'(HOLDOFF);

    state_e                  state_q, state_d;
    logic [WIDTH_BITS-1:0]   cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    drop_q, drop_d;
    logic                    trig_ok;

    assign trig_ok = trig && (width != '0);

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig_ok) begin
                    state_d = ACTIVE;
                    cnt_d   = width;
                end
            end

            ACTIVE: begin
                if ((RETRIGGER != 0) && trig_ok) begin
                    cnt_d = width;
                end else if (cnt_q <= CNT_ONE) begin
                    // <= rather than == keeps the counter from ever wrapping below 1.
                    done_d = 1'b1;
                    if (HOLDOFF > 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end

                if ((RETRIGGER == 0) && trig_ok) begin
                    drop_d = 1'b1;
                end
            end

            HOLD: begin
                drop_d = trig_ok;
                if (cnt_q <= CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign pulse_out    = (state_q == ACTIVE);
    assign busy         = (state_q != IDLE);
    assign pulse_done   = done_q;
    assign trig_dropped = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: four configurations, expected output events
// queued per instance and kind, matched by an independent negedge monitor.
module tb_pulse_stretcher;

    localparam int NI = 4;  // 0: default, 1: RETRIGGER=1, 2: HOLDOFF=3, 3: WIDTH_BITS=4
    localparam int NK = 6;
    localparam int K_PO_RISE = 0, K_PO_FALL = 1, K_BUSY_RISE = 2,
                   K_BUSY_FALL = 3, K_DONE = 4, K_DROP = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trig  [NI];
    logic [15:0] width [NI];
    logic        po    [NI];
    logic        bz    [NI];
    logic        dn    [NI];
    logic        dr    [NI];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_q [NI*NK][$];

    always #5 clk = ~clk;

    pulse_stretcher u0 (
        .clk(clk), .reset_n(reset_n), .trig(trig[0]), .width(width[0]),
        .pulse_out(po[0]), .busy(bz[0]), .pulse_done(dn[0]), .trig_dropped(dr[0])
    );

    pulse_stretcher #(.RETRIGGER(1)) u1 (
        .clk(clk), .reset_n(reset_n), .trig(trig[1]), .width(width[1]),
        .pulse_out(po[1]), .busy(bz[1]), .pulse_done(dn[1]), .trig_dropped(dr[1])
    );

    pulse_stretcher #(.HOLDOFF(3)) u2 (
        .clk(clk), .reset_n(reset_n), .trig(trig[2]), .width(width[2]),
        .pulse_out(po[2]), .busy(bz[2]), .pulse_done(dn[2]), .trig_dropped(dr[2])
    );

    pulse_stretcher #(.WIDTH_BITS(4)) u3 (
        .clk(clk), .reset_n(reset_n), .trig(trig[3]), .width(width[3][3:0]),
        .pulse_out(po[3]), .busy(bz[3]), .pulse_done(dn[3]), .trig_dropped(dr[3])
    );

    function automatic string kname(input int k);
        case (k)
            K_PO_RISE:   return "pulse_out_rise";
            K_PO_FALL:   return "pulse_out_fall";
            K_BUSY_RISE: return "busy_rise";
            K_BUSY_FALL: return "busy_fall";
            K_DONE:      return "pulse_done";
            default:     return "trig_dropped";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_evt(input int inst, input int kind, input int c);
        exp_q[inst*NK+kind].push_back(c);
    endtask

    // Pulse with no hold-off: busy tracks pulse_out, pulse_done on the first low cycle.
    task automatic expect_pulse(input int inst, input int rise, input int fall);
        expect_evt(inst, K_PO_RISE, rise);
        expect_evt(inst, K_BUSY_RISE, rise);
        expect_evt(inst, K_PO_FALL, fall);
        expect_evt(inst, K_BUSY_FALL, fall);
        expect_evt(inst, K_DONE, fall);
    endtask

    task automatic observe(input int inst, input int kind);
        int idx;
        int c;
        idx = inst*NK + kind;
        if (exp_q[idx].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL u%0d %s: unexpected event at cycle %0d, expected none", inst, kname(kind), cyc);
        end else begin
            c = exp_q[idx].pop_front();
            check($sformatf("u%0d %s cycle", inst, kname(kind)), cyc, c);
        end
    endtask

    // Cycle counter: cycle n spans posedge n .. posedge n+1.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: samples at negedge, turns level changes and strobes into events.
    initial begin
        logic po_prev [NI];
        logic bz_prev [NI];
        for (int i = 0; i < NI; i++) begin
            po_prev[i] = 1'b0;
            bz_prev[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (po[i] && !po_prev[i]) observe(i, K_PO_RISE);
                if (!po[i] && po_prev[i]) observe(i, K_PO_FALL);
                if (bz[i] && !bz_prev[i]) observe(i, K_BUSY_RISE);
                if (!bz[i] && bz_prev[i]) observe(i, K_BUSY_FALL);
                if (dn[i]) observe(i, K_DONE);
                if (dr[i]) observe(i, K_DROP);
                po_prev[i] = po[i];
                bz_prev[i] = bz[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle trigger in the current cycle.
    task automatic fire(input int inst, input int w);
        trig[inst]  = 1'b1;
        width[inst] = 16'(w);
        tick(1);
        trig[inst]  = 1'b0;
    endtask

    initial begin
        int t;
        int r;
        reset_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            trig[i]  = 1'b0;
            width[i] = 16'd0;
        end
        #22;
        reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d reset pulse_out", i), int'(po[i]), 0);
            check($sformatf("u%0d reset busy", i), int'(bz[i]), 0);
            check($sformatf("u%0d reset flags", i), int'({dn[i], dr[i]}), 0);
        end

        // Basic 5-cycle pulse.
        t = cyc;
        expect_pulse(0, t+1, t+6);
        fire(0, 5);
        tick(10);

        // Zero width is a silent no-op; width change mid-pulse is ignored.
        fire(0, 0);
        tick(4);
        t = cyc;
        expect_pulse(0, t+1, t+4);
        fire(0, 3);
        width[0] = 16'd9;
        tick(10);

        // No retrigger: drops mid-pulse and in the last active cycle, re-accept after done.
        t = cyc;
        expect_pulse(0, t+1, t+5);
        expect_evt(0, K_DROP, t+3);
        expect_pulse(0, t+6, t+10);
        expect_evt(0, K_DROP, t+8);
        expect_evt(0, K_DROP, t+9);
        expect_evt(0, K_DROP, t+10);
        fire(0, 4);
        tick(1);
        fire(0, 4);
        tick(2);
        fire(0, 4);
        tick(1);
        fire(0, 4);
        fire(0, 4);
        fire(0, 4);
        tick(8);

        // Retrigger mid-pulse and in the expiry cycle.
        t = cyc;
        expect_pulse(1, t+1, t+8);
        fire(1, 4);
        tick(2);
        fire(1, 4);
        tick(10);
        t = cyc;
        expect_pulse(1, t+1, t+6);
        fire(1, 2);
        tick(1);
        fire(1, 3);
        tick(8);

        // Hold-off of 3: busy extends, trigger in hold dropped, first acceptance after.
        t = cyc;
        expect_evt(2, K_PO_RISE, t+1);
        expect_evt(2, K_BUSY_RISE, t+1);
        expect_evt(2, K_PO_FALL, t+3);
        expect_evt(2, K_DONE, t+3);
        expect_evt(2, K_DROP, t+5);
        expect_evt(2, K_BUSY_FALL, t+6);
        expect_evt(2, K_PO_RISE, t+7);
        expect_evt(2, K_BUSY_RISE, t+7);
        expect_evt(2, K_PO_FALL, t+9);
        expect_evt(2, K_DONE, t+9);
        expect_evt(2, K_BUSY_FALL, t+12);
        fire(2, 2);
        tick(3);
        fire(2, 2);
        tick(1);
        fire(2, 2);
        tick(10);

        // Maximum length for a 4-bit counter: 15 cycles, no wrap.
        t = cyc;
        expect_pulse(3, t+1, t+16);
        fire(3, 15);
        tick(20);

        // Asynchronous reset mid-pulse, then a normal pulse after release.
        t = cyc;
        expect_evt(0, K_PO_RISE, t+1);
        expect_evt(0, K_BUSY_RISE, t+1);
        fire(0, 100);
        tick(19);
        #1;
        r = cyc;
        expect_evt(0, K_PO_FALL, r);
        expect_evt(0, K_BUSY_FALL, r);
        reset_n = 1'b0;
        #1;
        check("async reset pulse_out", int'(po[0]), 0);
        check("async reset busy", int'(bz[0]), 0);
        check("async reset pulse_done", int'(dn[0]), 0);
        check("async reset trig_dropped", int'(dr[0]), 0);
        tick(2);
        #2;
        reset_n = 1'b1;
        tick(2);
        t = cyc;
        expect_pulse(0, t+1, t+3);
        fire(0, 2);
        tick(10);

        for (int i = 0; i < NI*NK; i++) begin
            check($sformatf("u%0d %s pending events", i / NK, kname(i % NK)), exp_q[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
